// File: rtl/mask_centroid_pkg.sv
// Shared widths, FSM encoding and result-narrowing helpers for mask_centroid.
package mask_centroid_pkg;

   localparam int SUM_W = 32;
   localparam int CNT_W = 17;

   typedef enum logic [1:0] {ACCUM, DIVIDE, DONE} state_t;

   // A centroid never exceeds the largest coordinate; clamp keeps the narrowing total.
   function automatic logic [10:0] clamp_col(input logic [SUM_W-1:0] q);
      return (|q[SUM_W-1:11]) ? 11'h7ff : q[10:0];
   endfunction

   function automatic logic [9:0] clamp_row(input logic [SUM_W-1:0] q);
      return (|q[SUM_W-1:10]) ? 10'h3ff : q[9:0];
   endfunction

endpackage

// File: rtl/mask_centroid_if.sv
// Pixel stream in, per-frame centroid/bounding-box result out.
interface mask_centroid_if;
   import mask_centroid_pkg::*;

   logic             data_valid_in;
   logic [7:0]       pixel_data_in;
   logic [10:0]      hcount_in;
   logic [9:0]       vcount_in;
   logic [7:0]       threshold_in;

   logic             valid_out;
   logic             found_out;
   logic [10:0]      x_out;
   logic [9:0]       y_out;
   logic [CNT_W-1:0] count_out;
   logic [10:0]      xmin_out;
   logic [10:0]      xmax_out;
   logic [9:0]       ymin_out;
   logic [9:0]       ymax_out;
   logic             overrun_out;

   modport master (
      output data_valid_in, pixel_data_in, hcount_in, vcount_in, threshold_in,
      input  valid_out, found_out, x_out, y_out, count_out,
             xmin_out, xmax_out, ymin_out, ymax_out, overrun_out
   );

   modport slave (
      input  data_valid_in, pixel_data_in, hcount_in, vcount_in, threshold_in,
      output valid_out, found_out, x_out, y_out, count_out,
             xmin_out, xmax_out, ymin_out, ymax_out, overrun_out
   );

endinterface

// File: rtl/mask_centroid_divider.sv
// Restoring divider, one quotient bit per cycle; the first step runs on the start edge,
// so done_out is high WIDTH cycles after start_in. A zero divisor yields quotient 0.
module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             start_in,
   input  logic [WIDTH-1:0] dividend_in,
   input  logic [WIDTH-1:0] divisor_in,
   output logic [WIDTH-1:0] quotient_out,
   output logic             done_out
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] rem_q, quo_q, div_q;
   logic [CW-1:0]    cnt_q;

   logic [WIDTH-1:0] src_rem, src_quo, src_div, step_rem, step_quo;
   logic [WIDTH:0]   trial;
   logic             ge;

   always_comb begin
      src_rem = start_in ? '0 : rem_q;
      src_quo = start_in ? dividend_in : quo_q;
      src_div = start_in ? divisor_in : div_q;
      trial   = {src_rem, src_quo[WIDTH-1]};
      ge      = (trial >= {1'b0, src_div});
      // Remainder stays below the divisor, so the low WIDTH bits of the difference are exact.
      step_rem = ge ? (trial[WIDTH-1:0] - src_div) : trial[WIDTH-1:0];
      step_quo = {src_quo[WIDTH-2:0], ge};
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         rem_q    <= '0;
         quo_q    <= '0;
         div_q    <= '0;
         cnt_q    <= '0;
         done_out <= 1'b0;
      end else if (start_in) begin
         rem_q    <= step_rem;
         quo_q    <= step_quo;
         div_q    <= divisor_in;
         cnt_q    <= CW'(WIDTH - 1);
         done_out <= 1'b0;
      end else if (cnt_q != '0) begin
         rem_q    <= step_rem;
         quo_q    <= step_quo;
         cnt_q    <= cnt_q - 1'b1;
         done_out <= (cnt_q == CW'(1));
      end else begin
         done_out <= 1'b0;
      end
   end

   assign quotient_out = (div_q == '0) ? '0 : quo_q;

endmodule

// File: rtl/mask_centroid.sv
// Thresholds the pixel stream, accumulates hits per frame and emits centroid + bbox
// SUM_W+2 cycles after each frame end; accumulation continues while dividing.
module mask_centroid
   import mask_centroid_pkg::*;
#(
   parameter int HRES = 180,
   parameter int VRES = 320
) (
   input  logic          clk_in,
   input  logic          rst_in,
   mask_centroid_if.slave pix
);

   localparam logic [10:0] H_LAST = 11'(HRES - 1);
   localparam logic [9:0]  V_LAST = 10'(VRES - 1);

   state_t state_q, state_d;

   logic [CNT_W-1:0] live_cnt, nxt_cnt, snap_cnt;
   logic [SUM_W-1:0] live_sx, live_sy, nxt_sx, nxt_sy;
   logic [10:0]      live_xmin, live_xmax, nxt_xmin, nxt_xmax, snap_xmin, snap_xmax;
   logic [9:0]       live_ymin, live_ymax, nxt_ymin, nxt_ymax, snap_ymin, snap_ymax;

   logic             hit, frame_end, div_start, done_x, done_y, snap_found;
   logic [SUM_W-1:0] quo_x, quo_y;

   assign hit = pix.data_valid_in && (pix.hcount_in <= H_LAST) && (pix.vcount_in <= V_LAST)
                && (pix.pixel_data_in >= pix.threshold_in);
   assign frame_end = pix.data_valid_in && (pix.hcount_in == H_LAST) && (pix.vcount_in == V_LAST);

   // Live set including the current pixel; the frame-end snapshot takes these values.
   always_comb begin
      nxt_cnt  = live_cnt;
      nxt_sx   = live_sx;
      nxt_sy   = live_sy;
      nxt_xmin = live_xmin;
      nxt_xmax = live_xmax;
      nxt_ymin = live_ymin;
      nxt_ymax = live_ymax;
      if (hit) begin
         nxt_cnt = live_cnt + 1'b1;
         nxt_sx  = live_sx + SUM_W'(pix.hcount_in);
         nxt_sy  = live_sy + SUM_W'(pix.vcount_in);
         if (pix.hcount_in < live_xmin) nxt_xmin = pix.hcount_in;
         if (pix.hcount_in > live_xmax) nxt_xmax = pix.hcount_in;
         if (pix.vcount_in < live_ymin) nxt_ymin = pix.vcount_in;
         if (pix.vcount_in > live_ymax) nxt_ymax = pix.vcount_in;
      end
   end

   always_comb begin
      state_d   = state_q;
      div_start = 1'b0;
      unique case (state_q)
         ACCUM: begin
            if (frame_end) begin
               div_start = 1'b1;
               state_d   = DIVIDE;
            end
         end
         DIVIDE:  if (done_x && done_y) state_d = DONE;
         DONE:    state_d = ACCUM;
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) state_q <= ACCUM;
      else         state_q <= state_d;
   end

   // Every frame end clears the live set, even one dropped while dividing.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in || frame_end) begin
         live_cnt  <= '0;
         live_sx   <= '0;
         live_sy   <= '0;
         live_xmin <= '1;
         live_xmax <= '0;
         live_ymin <= '1;
         live_ymax <= '0;
      end else begin
         live_cnt  <= nxt_cnt;
         live_sx   <= nxt_sx;
         live_sy   <= nxt_sy;
         live_xmin <= nxt_xmin;
         live_xmax <= nxt_xmax;
         live_ymin <= nxt_ymin;
         live_ymax <= nxt_ymax;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         snap_cnt  <= '0;
         snap_xmin <= '1;
         snap_xmax <= '0;
         snap_ymin <= '1;
         snap_ymax <= '0;
      end else if (div_start) begin
         snap_cnt  <= nxt_cnt;
         snap_xmin <= nxt_xmin;
         snap_xmax <= nxt_xmax;
         snap_ymin <= nxt_ymin;
         snap_ymax <= nxt_ymax;
      end
   end

   seq_divider #(.WIDTH(SUM_W)) u_div_x (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .start_in     (div_start),
      .dividend_in  (nxt_sx),
      .divisor_in   (SUM_W'(nxt_cnt)),
      .quotient_out (quo_x),
      .done_out     (done_x)
   );

   seq_divider #(.WIDTH(SUM_W)) u_div_y (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .start_in     (div_start),
      .dividend_in  (nxt_sy),
      .divisor_in   (SUM_W'(nxt_cnt)),
      .quotient_out (quo_y),
      .done_out     (done_y)
   );

   assign snap_found = (snap_cnt != '0);

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         pix.valid_out   <= 1'b0;
         pix.found_out   <= 1'b0;
         pix.x_out       <= '0;
         pix.y_out       <= '0;
         pix.count_out   <= '0;
         pix.xmin_out    <= '0;
         pix.xmax_out    <= '0;
         pix.ymin_out    <= '0;
         pix.ymax_out    <= '0;
         pix.overrun_out <= 1'b0;
      end else begin
         pix.valid_out <= 1'b0;
         if (frame_end && (state_q != ACCUM)) pix.overrun_out <= 1'b1;
         if (state_q == DONE) begin
            pix.valid_out <= 1'b1;
            pix.found_out <= snap_found;
            pix.x_out     <= snap_found ? clamp_col(quo_x) : '0;
            pix.y_out     <= snap_found ? clamp_row(quo_y) : '0;
            pix.count_out <= snap_cnt;
            pix.xmin_out  <= snap_found ? snap_xmin : '0;
            pix.xmax_out  <= snap_found ? snap_xmax : '0;
            pix.ymin_out  <= snap_found ? snap_ymin : '0;
            pix.ymax_out  <= snap_found ? snap_ymax : '0;
         end
      end
   end

endmodule

// File: tb/tb_mask_centroid.sv
// Randomized and directed frames against a hit-list reference model of mask_centroid.
module tb_mask_centroid;

   localparam int HRES = 180;
   localparam int VRES = 320;
   localparam int LAT  = 34;

   typedef struct {
      int due; int found; int x; int y; int cnt;
      int xmin; int xmax; int ymin; int ymax;
   } res_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   res_t exp_q[$];
   int   hx[$];
   int   hy[$];
   int   acc_cyc = -1000;
   int   exp_ovr = 0;

   mask_centroid_if bus();

   mask_centroid #(.HRES(HRES), .VRES(VRES)) dut (
      .clk_in (clk),
      .rst_in (rst_n),
      .pix    (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference result from the list of hit coordinates of one frame.
   function automatic res_t model_result(input int due);
      res_t r;
      longint sx = 0, sy = 0;
      r = '{due, 0, 0, 0, 0, 0, 0, 0, 0};
      r.cnt = hx.size();
      if (r.cnt > 0) begin
         r.found = 1;
         r.xmin = hx[0]; r.xmax = hx[0]; r.ymin = hy[0]; r.ymax = hy[0];
         foreach (hx[i]) begin
            sx += hx[i];
            sy += hy[i];
            if (hx[i] < r.xmin) r.xmin = hx[i];
            if (hx[i] > r.xmax) r.xmax = hx[i];
            if (hy[i] < r.ymin) r.ymin = hy[i];
            if (hy[i] > r.ymax) r.ymax = hy[i];
         end
         r.x = int'(sx / r.cnt);
         r.y = int'(sy / r.cnt);
      end
      return r;
   endfunction

   task automatic px(input int vld, input int p, input int h, input int v, input int thr);
      bus.data_valid_in = (vld != 0);
      bus.pixel_data_in = 8'(p);
      bus.hcount_in     = 11'(h);
      bus.vcount_in     = 10'(v);
      bus.threshold_in  = 8'(thr);
      if (vld != 0 && h < HRES && v < VRES && p >= thr) begin
         hx.push_back(h);
         hy.push_back(v);
      end
      if (vld != 0 && h == HRES - 1 && v == VRES - 1) begin
         // Busy from the cycle after acceptance through the result cycle's predecessor.
         if (cyc - acc_cyc >= 1 && cyc - acc_cyc < LAT) begin
            exp_ovr = 1;
         end else begin
            exp_q.push_back(model_result(cyc + LAT));
            acc_cyc = cyc;
         end
         hx.delete();
         hy.delete();
      end
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      bus.data_valid_in = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_valid"}, bus.valid_out, 0);
      chk({tag, "_found"}, bus.found_out, 0);
      chk({tag, "_x"}, bus.x_out, 0);
      chk({tag, "_y"}, bus.y_out, 0);
      chk({tag, "_count"}, bus.count_out, 0);
      chk({tag, "_xmin"}, bus.xmin_out, 0);
      chk({tag, "_xmax"}, bus.xmax_out, 0);
      chk({tag, "_ymin"}, bus.ymin_out, 0);
      chk({tag, "_ymax"}, bus.ymax_out, 0);
      chk({tag, "_overrun"}, bus.overrun_out, 0);
   endtask

   task automatic do_reset(input int n);
      bus.data_valid_in = 1'b0;
      rst_n = 1'b0;
      exp_q.delete();
      hx.delete();
      hy.delete();
      acc_cyc = -1000;
      exp_ovr = 0;
      repeat (n) begin
         @(posedge clk); #1;
      end
      check_zero("in_reset");
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   always @(negedge clk) begin : mon
      res_t e;
      if (bus.valid_out) begin
         if (exp_q.size() == 0) begin
            chk("spurious_valid", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("latency", cyc, e.due);
            chk("found", bus.found_out, e.found);
            chk("x", bus.x_out, e.x);
            chk("y", bus.y_out, e.y);
            chk("count", bus.count_out, e.cnt);
            chk("xmin", bus.xmin_out, e.xmin);
            chk("xmax", bus.xmax_out, e.xmax);
            chk("ymin", bus.ymin_out, e.ymin);
            chk("ymax", bus.ymax_out, e.ymax);
            chk("overrun", bus.overrun_out, exp_ovr);
         end
      end
   end

   initial begin
      bus.data_valid_in = 1'b0;
      bus.pixel_data_in = '0;
      bus.hcount_in     = '0;
      bus.vcount_in     = '0;
      bus.threshold_in  = '0;
      #1;
      do_reset(3);
      check_zero("reset");

      // Single hit.
      px(1, 255, 10, 20, 128);
      px(1, 0, HRES - 1, VRES - 1, 128);
      idle(40);

      // Two hits.
      px(1, 200, 0, 0, 100);
      px(1, 200, 3, 5, 100);
      px(1, 0, HRES - 1, VRES - 1, 100);
      idle(40);

      // Zero-hit frame.
      px(1, 0, 7, 7, 1);
      px(1, 0, HRES - 1, VRES - 1, 1);
      idle(40);

      // Hit in the cycle right after frame end belongs to the next frame.
      px(1, 90, 40, 40, 80);
      px(1, 0, HRES - 1, VRES - 1, 80);
      px(1, 255, 0, 0, 80);
      idle(40);
      px(1, 0, HRES - 1, VRES - 1, 80);
      idle(40);

      // Reset ten cycles into a division, then a clean frame.
      px(1, 255, 100, 200, 10);
      px(1, 0, HRES - 1, VRES - 1, 10);
      idle(9);
      do_reset(2);
      check_zero("post_reset");
      idle(40);
      px(1, 30, 5, 6, 20);
      px(1, 30, 9, 300, 20);
      px(1, 0, HRES - 1, VRES - 1, 20);
      idle(40);

      // Frame end during division is dropped and flags overrun.
      px(1, 200, 60, 70, 50);
      px(1, 0, HRES - 1, VRES - 1, 50);
      idle(5);
      px(1, 200, 1, 1, 50);
      px(1, 255, HRES - 1, VRES - 1, 50);
      idle(40);
      chk("overrun_sticky", bus.overrun_out, 1);

      // Random sparse frames: out-of-range coordinates, invalid cycles, random gaps.
      for (int f = 0; f < 12; f++) begin
         int thr, n;
         thr = $urandom_range(0, 255);
         n   = $urandom_range(0, 10);
         for (int i = 0; i < n; i++) begin
            int h, v;
            h = ($urandom_range(0, 7) == 0) ? $urandom_range(HRES, 2047) : $urandom_range(0, HRES - 1);
            v = ($urandom_range(0, 7) == 0) ? $urandom_range(VRES, 1023) : $urandom_range(0, VRES - 1);
            px(($urandom_range(0, 5) != 0) ? 1 : 0, $urandom_range(0, 255), h, v, thr);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
         end
         px(1, $urandom_range(0, 255), HRES - 1, VRES - 1, thr);
         idle($urandom_range(0, 45));
      end
      idle(40);

      // Whole frame at the threshold value.
      for (int v = 0; v < VRES; v++)
         for (int h = 0; h < HRES; h++)
            px(1, 50, h, v, 50);
      idle(40);

      chk("pending_results", exp_q.size(), 0);
      chk("overrun_final", bus.overrun_out, exp_ovr);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
